// File: rtl/clk1_capture_fifo.sv
// clk1_capture_fifo
//   clk_1-domain capture stage in front of the CRC datapath. Words offered on
//   in_valid are queued in a DEPTH-entry register FIFO. The head entry is
//   presented to the clk_2 CDC bridge through a valid/ready handshake.
//   The block also reports occupancy, a full flag and a sticky overflow flag.
//
//   Build option: define CLK1_FLAG_TOGGLE_EN to make clk1_flag a level that
//   toggles on every pop, which suits a 2-flop synchronizer plus an edge
//   detector on the clk_2 side. With the macro undefined, clk1_flag is a
//   1-cycle pulse that follows each pop. The port list is the same in both
//   builds.
module clk1_capture_fifo #(
    parameter int MSG_W  = 60,
    parameter int MODE_W = 1,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [MSG_W-1:0]  message,
    input  logic [MODE_W-1:0] mode,
    input  logic              CRC,
    input  logic              ovf_clr,
    input  logic              out_ready,
    output logic [MSG_W-1:0]  clk1_message,
    output logic [MODE_W-1:0] clk1_mode,
    output logic              clk1_CRC,
    output logic              clk1_valid,
    output logic              clk1_flag,
    output logic              full,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = MSG_W + MODE_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               flag_q, flag_d;

    logic               push;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    // Handshake qualification: a full FIFO still accepts a word when the head
    // leaves in the same cycle, so no slot is wasted on back-to-back traffic.
    always_comb begin
        pop  = clk1_valid && out_ready;
        push = in_valid && (!full || pop);
        drop = in_valid && !push;
    end

    // Next-state for pointers, occupancy, sticky overflow and pop flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (pop && !push)
            count_d = count_q - CNT_ONE;

        // A dropped word outranks a clear so that no loss goes unreported.
        if (drop)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;

`ifdef CLK1_FLAG_TOGGLE_EN
        flag_d = flag_q ^ pop;
`else
        flag_d = pop;
`endif
    end

    // State and storage registers. The reset clears the storage so that the
    // head outputs read zero after reset.
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            flag_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            flag_q   <= flag_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {message, mode, CRC};
            end
        end
    end

    // The head outputs are a mux over registered storage only. There is no
    // path from the input side to these outputs.
    always_comb begin
        head         = mem_q[rd_ptr_q];
        clk1_message = head[ENTRY_W-1 -: MSG_W];
        clk1_mode    = head[MODE_W:1];
        clk1_CRC     = head[0];
        clk1_valid   = (count_q != '0);
        full         = (count_q == CNT_DEPTH);
        overflow     = ovf_q;
        clk1_flag    = flag_q;
        count        = count_q;
    end

endmodule

// File: doc/clk1_capture_fifo.md
Name: clk1_capture_fifo

Overview:
- Parametrised clk_1-domain input capture stage for the CRC datapath.
- Accepts message/mode/CRC words on in_valid into a DEPTH-entry register FIFO and presents them to the downstream consumer (CDC bridge toward clk_2) via a valid/ready handshake.
- Adds back-to-back burst buffering, overflow detection and occupancy reporting; the earlier single-register capture has none of these.

Parameters:
- MSG_W, 60, message width in bits (>=1)
- MODE_W, 1, mode field width in bits (>=1)
- DEPTH, 4, FIFO entries; power of two, >=2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, do not override)

Ports:
- clk_1  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk_1
- in_valid  in  1  input word present this cycle
- message  in  MSG_W  input message
- mode  in  MODE_W  input mode
- CRC  in  1  input CRC-select bit
- ovf_clr  in  1  clears sticky overflow
- out_ready  in  1  consumer accepts head entry
- clk1_message  out  MSG_W  head-entry message
- clk1_mode  out  MODE_W  head-entry mode
- clk1_CRC  out  1  head-entry CRC bit
- clk1_valid  out  1  head entry valid (FIFO not empty)
- clk1_flag  out  1  pop indicator (see Optional Feature)
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a push was dropped
- count  out  CNT_W  current occupancy

Behaviour:
- Reset (rst_n low at a clock edge):
  - wr_ptr, rd_ptr and count go to 0.
  - All storage entries go to 0, so clk1_message, clk1_mode and clk1_CRC read 0.
  - clk1_valid, full, overflow and clk1_flag go to 0.
  - Reset has priority over all other inputs; a reset mid-burst discards all entries.
- Push = in_valid && (!full || pop). The entry {message, mode, CRC} is written at wr_ptr, which then increments and wraps modulo DEPTH.
- Pop = clk1_valid && out_ready. rd_ptr increments and wraps modulo DEPTH.
- Outputs are driven from the storage entry at rd_ptr (registered storage, combinational mux). No combinational path runs from in_valid to any output.
- Latency: a word pushed into an empty FIFO at edge N appears with clk1_valid=1 after edge N (1 cycle). No bypass.
- count: +1 on push-only, -1 on pop-only, unchanged on push+pop or on neither.
- full = (count == DEPTH); clk1_valid = (count != 0).
- Full with push and pop in the same cycle: both happen, count stays at DEPTH, and there is no overflow.
- Full with push and no pop: the word is dropped, storage is unchanged, and overflow is set on the next edge.
- Empty with pop request: out_ready is ignored (clk1_valid=0) and nothing changes.
- overflow is sticky. ovf_clr=1 clears it on the next edge. If ovf_clr and a dropped push occur in the same cycle, set wins and overflow=1.
- Head data stays stable while clk1_valid=1 and out_ready=0.
- clk1_flag, default build: 1-cycle pulse registered from the pop (high the cycle after the pop edge).

Optional Feature:
- Macro: CLK1_FLAG_TOGGLE_EN.
- Defined: clk1_flag becomes a level that toggles on every pop; reset value is 0. This is intended for a 2-flop synchronizer plus edge detect in clk_2.
- Undefined: clk1_flag is the 1-cycle pop pulse described above.
- Port list is identical in both builds.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then in_valid=0 -> all outputs 0, count=0, clk1_valid=0.
- Single word: message=60'h0123_4567_89AB_CDE, mode=1, CRC=1, out_ready=0 -> after 1 edge clk1_valid=1, outputs match, count=1, and the outputs hold for 10 cycles; then out_ready=1 for 1 cycle -> count=0, clk1_flag pulses once (or toggles 0->1 under CLK1_FLAG_TOGGLE_EN).
- Burst fill and overflow: DEPTH=4, out_ready=0, 5 consecutive pushes of 1..5 -> full=1 after the 4th, overflow=1 after the 5th, count=4; drain with out_ready=1 -> pops 1,2,3,4 in order, word 5 absent.
- Full with simultaneous push+pop: FIFO full (1..4), in_valid=1 with message=9 and out_ready=1 -> pops 1, count stays 4, overflow stays 0; subsequent drain yields 2,3,4,9.
- Wrap-around: continuous push+pop of 0..19 with DEPTH=4 -> output order 0..19, count never exceeds 1, no overflow; ovf_clr pulse asserted in the same cycle as a dropped push -> overflow remains 1, and ovf_clr alone next cycle -> 0.
- Reset mid-operation: 3 entries queued, rst_n=0 for one edge -> count=0, clk1_valid=0, outputs 0; first push after reset appears as the head.
